// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path.
// State encodings and widths used by the scheduler and its FIFO.
package audio_pkg;

  localparam int AUDIO_W        = 32;
  localparam int UNDERRUN_CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef logic [1:0] state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO.
// Pointers carry one extra wrap bit so full and empty stay distinct.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);

endmodule

// File: rtl/audio_sample_scheduler.sv
// Paces buffered audio samples onto x, one every DIV clocks.
// Sequences prime/run/drain and tracks underruns.
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int                DATA_W      = AUDIO_W,
  parameter int                DIV         = 4,
  parameter int                DEPTH       = 4,
  parameter int                PRIME_LEVEL = 4,
  parameter logic [DATA_W-1:0] MUTE_VALUE  = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear_status,
  input  logic                      src_valid,
  input  logic [DATA_W-1:0]         src_data,
  output logic                      src_ready,
  output logic [DATA_W-1:0]         x,
  output logic                      x_strobe,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count,
  output logic                      busy
);

  localparam int CW = $clog2(DIV);
  localparam int FW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [FW-1:0]     fifo_count;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              flush;
  logic              active;
  logic              tick;
  logic              start;
  logic              primed;
  logic              starve;

  assign active    = (state == S_RUN) || (state == S_DRAIN);
  assign tick      = active && (cnt == CW'(DIV-1));
  assign src_ready = ((state == S_PRIME) || (state == S_RUN)) && !full;
  assign push      = src_valid && src_ready;
  assign pop       = tick && !empty;
  assign starve    = tick && empty && (state == S_RUN);
  assign start     = (state == S_IDLE) && enable;
  assign busy      = (state != S_IDLE);

  // occupancy after this edge's push decides the leave-PRIME condition
  assign primed = ({1'b0, fifo_count} + {{FW{1'b0}}, push})
                  >= (FW+1)'(PRIME_LEVEL);

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .din     (src_data),
    .pop     (pop),
    .dout    (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          flush     = 1'b1;
        end else if (primed) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (tick && empty) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (!active || tick) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      x_strobe <= 1'b0;
    end else begin
      x_strobe <= 1'b0;
      if (pop) begin
        x        <= head;
        x_strobe <= 1'b1;
      end else if (starve) begin
        x        <= MUTE_VALUE;
        x_strobe <= 1'b1;
      end
    end
  end

  // a clear request wins over an underrun on the same edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (clear_status || start) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (starve) begin
      underrun <= 1'b1;
      if (underrun_count != '1)
        underrun_count <= underrun_count + UNDERRUN_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler.
// Pushes record expected samples; a monitor checks every strobe.
module tb_audio_sample_scheduler;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_status = 1'b0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = 32'd1;
  logic        src_ready;
  logic [31:0] x;
  logic        x_strobe;
  logic        underrun;
  logic [15:0] underrun_count;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  int          nstrobe = 0;
  int          npush = 0;
  int          cyc = 0;
  int          last = -1;
  int          bp;
  int          bs;
  logic [31:0] exp_q[$];

  audio_sample_scheduler #(
    .DATA_W      (32),
    .DIV         (DIV),
    .DEPTH       (4),
    .PRIME_LEVEL (4),
    .MUTE_VALUE  (32'd0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear_status   (clear_status),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .x              (x),
    .x_strobe       (x_strobe),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .busy           (busy)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_strobes(input int target, input int limit);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clock); #1;
      if (nstrobe >= target) hit = 1;
    end
    if (!hit) timeout("wait_strobes");
  endtask

  task automatic wait_pushes(input int target, input int limit);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clock); #1;
      if (npush >= target) hit = 1;
    end
    if (!hit) timeout("wait_pushes");
  endtask

  task automatic wait_idle(input int limit);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clock); #1;
      if (!busy) hit = 1;
    end
    if (!hit) timeout("wait_idle");
  endtask

  // source: a push on this edge queues its sample as the next expected x
  initial forever begin
    @(posedge clock);
    if (reset_n && src_valid && src_ready) begin
      exp_q.push_back(src_data);
      npush++;
      #1 src_data = src_data + 32'd1;
    end
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (x_strobe) begin
      nstrobe++;
      if (last >= 0) check("spacing", 32'(cyc - last), 32'(DIV));
      last = cyc;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got x=%0h expected no strobe", x);
      end else begin
        check("x", x, exp_q.pop_front());
      end
    end
    if (!busy) last = -1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_x", x, 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_strobe", 32'(x_strobe), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_ucount", 32'(underrun_count), 32'd0);
    @(negedge clock); #1;
    reset_n = 1'b1;

    // prime, play under backpressure, then drain
    @(negedge clock); #1;
    src_data = 32'd1;
    enable = 1'b1;
    src_valid = 1'b1;
    wait_pushes(4, 20);
    check("full_ready", 32'(src_ready), 32'd0);
    check("run_busy", 32'(busy), 32'd1);
    wait_strobes(8, 100);
    check("occupancy", 32'(npush - nstrobe), 32'd3);
    enable = 1'b0;
    src_valid = 1'b0;
    @(negedge clock); #1;
    check("drain_ready", 32'(src_ready), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    wait_strobes(11, 60);
    wait_idle(20);
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_last_x", x, 32'd11);
    check("drain_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clock);
    #1 check("x_hold", x, 32'd11);

    // underrun after a 4-sample prime
    src_data = 32'd1;
    bp = npush;
    bs = nstrobe;
    enable = 1'b1;
    src_valid = 1'b1;
    wait_pushes(bp + 4, 20);
    src_valid = 1'b0;
    repeat (3) exp_q.push_back(32'd0);
    wait_strobes(bs + 4, 40);
    check("ur_before", 32'(underrun), 32'd0);
    check("ucnt_before", 32'(underrun_count), 32'd0);
    wait_strobes(bs + 5, 20);
    check("ur_set", 32'(underrun), 32'd1);
    check("ucnt_1", 32'(underrun_count), 32'd1);
    wait_strobes(bs + 6, 20);
    check("ucnt_2", 32'(underrun_count), 32'd2);
    wait_strobes(bs + 7, 20);
    check("ucnt_3", 32'(underrun_count), 32'd3);
    check("ur_sticky", 32'(underrun), 32'd1);
    clear_status = 1'b1;
    @(negedge clock); #1;
    clear_status = 1'b0;
    check("clr_ur", 32'(underrun), 32'd0);
    check("clr_ucnt", 32'(underrun_count), 32'd0);
    enable = 1'b0;
    wait_idle(20);
    check("ur_drain_nostrobe", 32'(nstrobe), 32'(bs + 7));
    check("ur_drain_ucnt", 32'(underrun_count), 32'd0);
    check("ur_x_mute", x, 32'd0);

    // abort during prime, then re-prime from empty
    src_data = 32'd1;
    bp = npush;
    bs = nstrobe;
    enable = 1'b1;
    src_valid = 1'b1;
    wait_pushes(bp + 2, 20);
    enable = 1'b0;
    src_valid = 1'b0;
    @(negedge clock); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(src_ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    #1 check("abort_nostrobe", 32'(nstrobe), 32'(bs));
    src_data = 32'd100;
    bp = npush;
    enable = 1'b1;
    src_valid = 1'b1;
    wait_pushes(bp + 4, 20);
    wait_strobes(bs + 2, 40);
    enable = 1'b0;
    src_valid = 1'b0;
    wait_idle(60);
    check("reprime_q_empty", 32'(exp_q.size()), 32'd0);

    // clear racing an underrun tick, then async reset mid-run
    src_data = 32'd1;
    bp = npush;
    bs = nstrobe;
    enable = 1'b1;
    src_valid = 1'b1;
    wait_pushes(bp + 4, 20);
    src_valid = 1'b0;
    exp_q.push_back(32'd0);
    wait_strobes(bs + 5, 60);
    check("race_pre", 32'(underrun_count), 32'd1);
    repeat (3) @(negedge clock);
    #1 clear_status = 1'b1;
    exp_q.push_back(32'd0);
    @(negedge clock); #1;
    clear_status = 1'b0;
    check("race_strobe", 32'(nstrobe), 32'(bs + 6));
    check("race_ur", 32'(underrun), 32'd0);
    check("race_ucnt", 32'(underrun_count), 32'd0);
    exp_q.push_back(32'd0);
    wait_strobes(bs + 7, 20);
    check("race_after", 32'(underrun_count), 32'd1);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_x", x, 32'd0);
    check("arst_ready", 32'(src_ready), 32'd0);
    check("arst_ucnt", 32'(underrun_count), 32'd0);
    check("arst_ur", 32'(underrun), 32'd0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1 check("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
